imem_arbiter: RTL and testbench

//  Shares the single-port instruction memory between the CPU fetch port and a

---
 rtl/imem_arbiter_if.sv | 48 ++++
 rtl/imem_arbiter.sv | 98 +++++++++
 tb/tb_imem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and instruction-memory signal bundle for imem_arbiter
// IMEM_ALIGN_ERR_EN adds the align_err / align_owner debug signals.
interface imem_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_vld;
  logic [31:0] fetch_data;
  logic        ld_req;
  logic        ld_we;
  logic        ld_lock;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_vld;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_ALIGN_ERR_EN
  logic        align_err;
  logic        align_owner;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_vld, fetch_data, ld_gnt, ld_vld, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, align_err, align_owner
  );
  modport master (
    output fetch_req, fetch_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_vld, fetch_data, ld_gnt, ld_vld, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, align_err, align_owner
  );
`else
  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_vld, fetch_data, ld_gnt, ld_vld, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output fetch_req, fetch_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_vld, fetch_data, ld_gnt, ld_vld, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter between CPU fetch and boot loader
// IMEM_ALIGN_ERR_EN: misaligned requests are granted but not issued, and pulse align_err.
module imem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  imem_arbiter_if.slave bus
);
  localparam int WC_W = $clog2(STARVE_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(STARVE_MAX);

  logic [WC_W-1:0]    wait_cnt;
  logic               starve;
  logic               fetch_gnt_c;
  logic               ld_gnt_c;
  logic               any_gnt;
  logic               issue;
  logic               push_vld;
  logic [31:0]        sel_addr;
  logic [MEM_LAT-1:0] tag_vld;
  logic [MEM_LAT-1:0] tag_own;

  always_comb begin
    starve      = (wait_cnt == WC_MAX);
    // Loader yields to fetch unless locked or starved; the two terms are mutually exclusive.
    ld_gnt_c    = !reset && bus.ld_req && (bus.ld_lock || starve || !bus.fetch_req);
    fetch_gnt_c = !reset && bus.fetch_req && !bus.ld_lock && !(bus.ld_req && starve);
    any_gnt     = ld_gnt_c || fetch_gnt_c;
    sel_addr    = ld_gnt_c ? bus.ld_addr : bus.fetch_addr;
`ifdef IMEM_ALIGN_ERR_EN
    issue       = any_gnt && (sel_addr[1:0] == 2'b00);
`else
    issue       = any_gnt;
`endif
    push_vld    = issue && !(ld_gnt_c && bus.ld_we);
  end

`ifdef IMEM_ALIGN_ERR_EN
  logic align_owner_q;

  assign bus.align_err   = any_gnt && (sel_addr[1:0] != 2'b00);
  assign bus.align_owner = align_owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      align_owner_q <= 1'b0;
    end else if (bus.align_err) begin
      align_owner_q <= ld_gnt_c;
    end
  end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^sel_addr[1:0];
`endif

  assign bus.fetch_gnt = fetch_gnt_c;
  assign bus.ld_gnt    = ld_gnt_c;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && ld_gnt_c && bus.ld_we;
  assign bus.mem_addr  = {sel_addr[31:2], 2'b00};
  assign bus.mem_wdata = bus.ld_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!bus.ld_req || ld_gnt_c) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Tag stage k holds the request granted k+1 cycles ago; the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= push_vld;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_own[0] <= ld_gnt_c;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_own[i] <= tag_own[i-1];
    end
  end

  assign bus.fetch_vld  = tag_vld[MEM_LAT-1] && !tag_own[MEM_LAT-1];
  assign bus.ld_vld     = tag_vld[MEM_LAT-1] &&  tag_own[MEM_LAT-1];
  assign bus.fetch_data = bus.mem_rdata;
  assign bus.ld_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter with randomized traffic
module tb_imem_arbiter;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 3;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   denied      = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] shadow [256];
  logic [31:0] phys   [256];
  logic [31:0] rd_pipe [MEM_LAT];

  imem_arbiter_if bus();

  imem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model driven only by the DUT's memory bus.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) phys[bus.mem_addr[9:2]] <= bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? phys[bus.mem_addr[9:2]] : 32'($urandom);
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      logic efv, elv;
      logic [31:0] ed;
      efv = 1'b0; elv = 1'b0; ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        efv = !mon_e.own;
        elv = mon_e.own;
        ed  = mon_e.data;
      end
      chk("fetch_vld", {31'd0, bus.fetch_vld}, {31'd0, efv});
      chk("ld_vld", {31'd0, bus.ld_vld}, {31'd0, elv});
      if (efv) chk("fetch_data", bus.fetch_data, ed);
      if (elv) chk("ld_rdata", bus.ld_rdata, ed);
    end
  end

  task automatic cycle(input logic rst, input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic lk,
                       input logic [31:0] la, input logic [31:0] wd);
    logic el, ef, en, mis;
    logic [31:0] a;
    @(posedge clk);
    #1;
    reset = rst;
    bus.fetch_req = fr; bus.fetch_addr = fa;
    bus.ld_req = lr; bus.ld_we = lw; bus.ld_lock = lk; bus.ld_addr = la; bus.ld_wdata = wd;
    if (rst) begin
      sb.delete();
      denied = 0;
    end
    el  = !rst && lr && (lk || denied >= STARVE_MAX || !fr);
    ef  = !rst && fr && !lk && !el;
    a   = el ? la : fa;
    mis = (a[1:0] != 2'b00);
`ifdef IMEM_ALIGN_ERR_EN
    en  = (el || ef) && !mis;
`else
    en  = el || ef;
`endif
    @(negedge clk);
    chk("fetch_gnt", {31'd0, bus.fetch_gnt}, {31'd0, ef});
    chk("ld_gnt", {31'd0, bus.ld_gnt}, {31'd0, el});
    chk("mem_en", {31'd0, bus.mem_en}, {31'd0, en});
`ifdef IMEM_ALIGN_ERR_EN
    chk("align_err", {31'd0, bus.align_err}, {31'd0, (el || ef) && mis});
`endif
    if (en) begin
      chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, el && lw});
      if (el && lw) chk("mem_wdata", bus.mem_wdata, wd);
    end else begin
      chk("mem_we_idle", {31'd0, bus.mem_we}, 32'd0);
    end
    if (en && el && lw) shadow[a[9:2]] = wd;
    else if (en) sb.push_back('{own: el, data: shadow[a[9:2]], due: cyc + MEM_LAT});
    if (rst || !lr || el) denied = 0;
    else if (denied < STARVE_MAX) denied++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[31:10] = 22'd0;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++)
      cycle(1, 1, rand_addr(), 1, 1, 0, rand_addr(), 32'($urandom));
    // Load every word through the loader under lock so both memory views agree.
    for (int i = 0; i < 256; i++)
      cycle(0, 1'($urandom), rand_addr(), 1, 1, 1, 32'(i << 2), 32'($urandom));
    cycle(0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < MEM_LAT; i++) cycle(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 12; i++)
      cycle(0, 1, 32'(i << 2), 1, 0, 0, 32'(32'h100 + (i << 2)), 32'h0);
    cycle(0, 1, 32'h4, 1, 1, 1, 32'h40, 32'hDEADBEEF);
    cycle(0, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 1, 32'hA, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      cycle(0, ~i[0], 32'(i << 4), i[0], 0, 0, 32'(32'h200 + (i << 4)), 32'h0);
    cycle(0, 1, 32'h10, 0, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 32'h14, 1, 0, 0, 32'h18, 32'h0);
    cycle(1, 1, 32'h14, 1, 0, 0, 32'h18, 32'h0);
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 99) == 0, 1'($urandom), rand_addr(),
            1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
            rand_addr(), 32'($urandom));
    for (int i = 0; i < MEM_LAT + 3; i++) cycle(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
